multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: INSTRET_W, default 32, width of the retired-instruction counter.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 opcode  in  7  instruction bits [6:0], valid from DECODE onward.
REQ-006 mem_ready  in  1  memory handshake; the current access completes in the cycle this is high.
REQ-007 state  out  4  current FSM state code.
REQ-008 Strobes, each out, 1 bit: pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, iord (1 = data address).
REQ-009 alu_src_a  out  2  ALU A operand select: 0 = PC, 1 = rs1, 2 = old PC.
REQ-010 alu_src_b  out  2  ALU B operand select: 0 = rs2, 1 = const 4, 2 = imm.
REQ-011 alu_op  out  2  to ALU decoder: 00 branch, 01 R-type, 10 add (address/PC), 11 load.
REQ-012 pc_source  out  2  next-PC select: 0 = ALU result, 1 = ALUOut register, 2 = jump target.
REQ-013 mem_to_reg  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC+4.
REQ-014 illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
REQ-015 instret  out  INSTRET_W  count of completed instructions.

Function
REQ-016 State codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, ALU_WB=7, BRANCH=8, JAL=9.
REQ-017 Outputs SHALL be Moore-decoded from state, except the mem_ready-qualified strobes in REQ-018.
REQ-018 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=10, pc_source=0. On mem_ready: ir_write=1, pc_write=1, next DECODE. Otherwise hold FETCH with ir_write=0 and pc_write=0.
REQ-019 DECODE (1 cycle): alu_src_a=2, alu_src_b=2, alu_op=10, which precomputes the branch/jump target.
REQ-020 DECODE next state by opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 1100011 -> BRANCH; 1101111 -> JAL; any other -> FETCH with illegal_instr=1 for that cycle.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=2. alu_op=11 for a load, 10 for a store. Next MEM_READ (load) or MEM_WRITE (store).
REQ-022 MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
REQ-023 MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready, then FETCH; the store retires.
REQ-024 MEM_WB: reg_write=1, mem_to_reg=1, then FETCH; the load retires.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=01, then ALU_WB.
REQ-026 ALU_WB: reg_write=1, mem_to_reg=0, then FETCH; the instruction retires.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=00, pc_write_cond=1, pc_source=1, then FETCH; the instruction retires.
REQ-028 JAL: pc_write=1, pc_source=2, reg_write=1, mem_to_reg=2, then FETCH; the instruction retires.
REQ-029 Outputs not listed for a state SHALL be 0.
REQ-030 Retirement: instret increments by 1 on the clock edge leaving a retiring state; it wraps modulo 2^INSTRET_W.
REQ-031 Illegal instructions SHALL NOT increment instret.
REQ-032 Latency, with mem_ready held high: R-type 4 cycles, load 5, store 4, branch 3, JAL 3.
REQ-033 mem_ready SHALL be ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-034 When rst=1 at a clock edge: state=FETCH and instret=0, overriding any transition, including a pending memory access.
REQ-035 In the first cycle after reset, outputs SHALL be the FETCH values; illegal_instr=0.

Verification
REQ-036 Reset, then mem_ready=1, opcode=0110011 -> state sequence 0,1,6,7,0; reg_write=1 only in state 7; alu_op=01 in state 6; instret=1.
REQ-037 Load (0000011) with mem_ready low for 3 cycles in MEM_READ -> state 3 held 4 cycles, then 4, then 0; mem_read=1 throughout state 3; alu_op=11 in state 2.
REQ-038 Store (0100011) -> sequence 0,1,2,5,0; mem_write=1 only in state 5; reg_write never asserted.
REQ-039 opcode=1111111 -> DECODE goes to FETCH, illegal_instr pulses for 1 cycle, instret unchanged.
REQ-040 Assert rst during MEM_WRITE with mem_ready=0 -> next cycle state=0, instret=0, mem_write=0.
REQ-041 Preload instret to all ones and run a BRANCH -> instret wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore-decoded datapath controls plus retired-instruction counter.
// State advances every cycle except FETCH/MEM_READ/MEM_WRITE, which stall until mem_ready.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic [3:0]           state,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 iord,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [1:0]           mem_to_reg,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JAL       = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 2'b00;
    pc_source     = 2'd0;
    mem_to_reg    = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        alu_op    = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d       = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == OP_LOAD) ? 2'b11 : 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'd1;
        alu_op    = 2'b01;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        reg_write  = 1'b1;
        mem_to_reg = 2'd2;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + INSTRET_W'(retire);
  end

  // Reset wins over any pending transition, including a stalled memory access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction phase lists drive the DUT and predict every cycle's outputs.
module tb_multicycle_control;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic [3:0]    state;
  logic          pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, iord;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, pc_source, mem_to_reg;
  logic          illegal_instr;
  logic [IW-1:0] instret;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] model_cnt;

  multicycle_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .state(state),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .instret(instret)
  );

  always #5 clk = ~clk;

  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, iord,
                     alu_src_a, alu_src_b, alu_op, pc_source, mem_to_reg};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Control table per state, straight from the per-state output lists.
  function automatic logic [16:0] exp_ctrl(input int st, input bit ld, input bit rdy);
    logic pw, pwc, irw, mr, mw, rw, io;
    logic [1:0] a, b, op, ps, m2r;
    {pw, pwc, irw, mr, mw, rw, io} = '0;
    {a, b, op, ps, m2r} = '0;
    case (st)
      0: begin mr = 1; b = 1; op = 2; pw = rdy; irw = rdy; end
      1: begin a = 2; b = 2; op = 2; end
      2: begin a = 1; b = 2; op = ld ? 2'd3 : 2'd2; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin a = 1; op = 1; end
      7: begin rw = 1; end
      8: begin a = 1; pwc = 1; ps = 1; end
      9: begin pw = 1; ps = 2; rw = 1; m2r = 2; end
      default: ;
    endcase
    return {pw, pwc, irw, mr, mw, rw, io, a, b, op, ps, m2r};
  endfunction

  // One cycle: drive mem_ready, check everything mid-cycle, advance past the edge.
  task automatic cyc(input int exp_st, input bit ld, input bit rdy, input bit exp_ill);
    mem_ready = rdy;
    @(negedge clk);
    check_val($sformatf("state@%0d", exp_st), 32'(state), 32'(exp_st));
    check_val($sformatf("ctrl@%0d", exp_st), 32'(act_ctrl), 32'(exp_ctrl(exp_st, ld, rdy)));
    check_val($sformatf("illegal@%0d", exp_st), 32'(illegal_instr), 32'(exp_ill));
    check_val($sformatf("instret@%0d", exp_st), 32'(instret), 32'(model_cnt));
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // fw/mw: cycles mem_ready stays low in FETCH / data access (-1 = random).
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit abort);
    int nf, nm;
    bit ld;
    nf = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    nm = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
    ld = (op == 7'b0000011);
    opcode = 7'($urandom);
    repeat (nf) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    opcode = op;
    if (!is_legal(op)) begin
      cyc(1, 0, 1'($urandom), 1);
      return;
    end
    cyc(1, 0, 1'($urandom), 0);
    case (op)
      7'b0000011: begin
        cyc(2, 1, 1'($urandom), 0);
        repeat (nm) cyc(3, 1, 0, 0);
        cyc(3, 1, 1, 0);
        cyc(4, 1, 1'($urandom), 0);
        model_cnt++;
      end
      7'b0100011: begin
        cyc(2, 0, 1'($urandom), 0);
        repeat (nm) cyc(5, 0, 0, 0);
        if (abort) begin
          rst = 1'b1;
          mem_ready = 1'b0;
          @(posedge clk);
          #1;
          rst = 1'b0;
          model_cnt = '0;
          return;
        end
        cyc(5, 0, 1, 0);
        model_cnt++;
      end
      7'b0110011: begin
        cyc(6, 0, 1'($urandom), 0);
        cyc(7, 0, 1'($urandom), 0);
        model_cnt++;
      end
      7'b1100011: begin
        cyc(8, 0, 1'($urandom), 0);
        model_cnt++;
      end
      default: begin
        cyc(9, 0, 1'($urandom), 0);
        model_cnt++;
      end
    endcase
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] legal [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b1101111};
    logic [6:0] op;
    if ($urandom_range(0, 6) == 0) begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
      return op;
    end
    return legal[$urandom_range(0, 4)];
  endfunction

  initial begin
    rst = 1'b1;
    opcode = '0;
    mem_ready = 1'b0;
    model_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(7'b0110011, 0, 0, 0);
    check_val("rtype_instret", 32'(instret), 32'd1);
    run_instr(7'b0000011, 0, 3, 0);
    run_instr(7'b0100011, 0, 0, 0);
    run_instr(7'b1111111, 0, 0, 0);
    run_instr(7'b1101111, 1, 1, 0);
    run_instr(7'b1100011, 2, 0, 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 80; i++) run_instr(rand_op(), -1, -1, 0);

    run_instr(7'b0100011, 0, 2, 1);
    cyc(0, 0, 0, 0);
    check_val("abort_instret", 32'(instret), 32'd0);

    for (int i = 0; i < 15; i++) run_instr(7'b0110011, -1, -1, 0);
    check_val("pre_wrap", 32'(instret), 32'd15);
    run_instr(7'b1100011, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check_val("wrap", 32'(instret), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
